// File: rtl/controlador_es_hlt_if.sv
// Signals between the decode stage and the IN/OUT/HLT sequencer.
// The decode stage drives opcode/data/board inputs; the sequencer answers with stall and results.
interface controlador_es_hlt_if #(
   parameter int LARGURA_CHAVES = 16
);
   logic [5:0]                opcode;
   logic [31:0]               dado_rs;
   logic [LARGURA_CHAVES-1:0] chaves;
   logic                      botao_confirma_n;
   logic                      botao_continua_n;
   logic                      stall_pc;
   logic                      es_reg_write;
   logic [31:0]               dado_entrada;
   logic [31:0]               saida_display;
   logic                      saida_valida;
   logic                      led_espera;
   logic                      parado;

   // Flow control: while stall_pc is high the decode stage holds PC and opcode;
   // an instruction is consumed at the first rising edge where stall_pc is low.
   modport master (
      output opcode, dado_rs, chaves, botao_confirma_n, botao_continua_n,
      input  stall_pc, es_reg_write, dado_entrada, saida_display, saida_valida,
      input  led_espera, parado
   );

   modport slave (
      input  opcode, dado_rs, chaves, botao_confirma_n, botao_continua_n,
      output stall_pc, es_reg_write, dado_entrada, saida_display, saida_valida,
      output led_espera, parado
   );
endinterface

// File: rtl/controlador_es_hlt.sv
// IN/OUT/HLT sequencer beside the control decoder: debounces the confirm/continue
// buttons, captures switches for IN, latches the display for OUT and halts on HLT.
module controlador_es_hlt #(
   parameter int LARGURA_CHAVES  = 16,
   parameter int DEBOUNCE_CICLOS = 500000
) (
   input  logic                 clock,
   input  logic                 reset_n,
   controlador_es_hlt_if.slave  bus,
   output logic [2:0]           estado_o
);
   localparam logic [5:0] OP_IN  = 6'b100000;
   localparam logic [5:0] OP_OUT = 6'b100001;
   localparam logic [5:0] OP_HLT = 6'b100011;
   localparam int CW = $clog2(DEBOUNCE_CICLOS);

   typedef enum logic [2:0] {
      OCIOSO, ESPERA_PRESS, ESPERA_SOLTA, ESCREVE, PARADO, LIBERA
   } estado_t;

   estado_t                   estado_q, estado_d;
   logic [31:0]               dado_entrada_q, dado_entrada_d;
   logic [31:0]               saida_display_q, saida_display_d;
   logic [LARGURA_CHAVES-1:0] chaves_w;

   // Index 0 = confirm, index 1 = continue; all levels are pressed = 1.
   logic [1:0]    botao_w;
   logic [1:0]    sinc1_q, sinc2_q;
   logic [1:0]    nivel_q, nivel_d;
   logic [1:0]    pulso_q;
   logic [CW-1:0] cont_q [2];
   logic [CW-1:0] cont_d [2];

   logic stall_w, escreve_w, led_w, parado_w, valida_w;

   assign chaves_w = bus.chaves;
   assign botao_w  = {~bus.botao_continua_n, ~bus.botao_confirma_n};

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         nivel_d[b] = nivel_q[b];
         cont_d[b]  = '0;
         if (sinc2_q[b] != nivel_q[b]) begin
            if (cont_q[b] == CW'(DEBOUNCE_CICLOS - 1)) nivel_d[b] = ~nivel_q[b];
            else                                        cont_d[b]  = cont_q[b] + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sinc1_q   <= '0;
         sinc2_q   <= '0;
         nivel_q   <= '0;
         pulso_q   <= '0;
         cont_q[0] <= '0;
         cont_q[1] <= '0;
      end else begin
         sinc1_q   <= botao_w;
         sinc2_q   <= sinc1_q;
         nivel_q   <= nivel_d;
         pulso_q   <= nivel_d & ~nivel_q;
         cont_q[0] <= cont_d[0];
         cont_q[1] <= cont_d[1];
      end
   end

   always_comb begin
      estado_d        = estado_q;
      dado_entrada_d  = dado_entrada_q;
      saida_display_d = saida_display_q;
      stall_w         = 1'b0;
      escreve_w       = 1'b0;
      led_w           = 1'b0;
      parado_w        = 1'b0;
      valida_w        = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (bus.opcode == OP_IN) begin
               stall_w  = 1'b1;
               estado_d = ESPERA_PRESS;
            end else if (bus.opcode == OP_OUT) begin
               saida_display_d = bus.dado_rs;
               valida_w        = 1'b1;
            end else if (bus.opcode == OP_HLT) begin
               stall_w  = 1'b1;
               estado_d = PARADO;
            end
         end
         ESPERA_PRESS: begin
            stall_w = 1'b1;
            led_w   = 1'b1;
            if (pulso_q[0]) begin
               dado_entrada_d = 32'(chaves_w);
               estado_d       = ESPERA_SOLTA;
            end
         end
         ESPERA_SOLTA: begin
            stall_w = 1'b1;
            if (!nivel_q[0]) estado_d = ESCREVE;
         end
         ESCREVE: begin
            escreve_w = 1'b1;
            estado_d  = OCIOSO;
         end
         PARADO: begin
            stall_w  = 1'b1;
            parado_w = 1'b1;
            if (pulso_q[1]) estado_d = LIBERA;
         end
         LIBERA:  estado_d = OCIOSO;
         default: estado_d = OCIOSO;
      endcase
      // Outputs drop the moment reset asserts, even though opcode may still decode as IN/HLT.
      if (!reset_n) begin
         stall_w   = 1'b0;
         escreve_w = 1'b0;
         led_w     = 1'b0;
         parado_w  = 1'b0;
         valida_w  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q        <= OCIOSO;
         dado_entrada_q  <= '0;
         saida_display_q <= '0;
      end else begin
         estado_q        <= estado_d;
         dado_entrada_q  <= dado_entrada_d;
         saida_display_q <= saida_display_d;
      end
   end

   assign bus.stall_pc      = stall_w;
   assign bus.es_reg_write  = escreve_w;
   assign bus.led_espera    = led_w;
   assign bus.parado        = parado_w;
   assign bus.saida_valida  = valida_w;
   assign bus.dado_entrada  = dado_entrada_q;
   assign bus.saida_display = saida_display_q;
   assign estado_o          = estado_q;
endmodule
